// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode constants, a clog2 helper
// and the parameter legality check used at elaboration time.
package fifo_pkg;

  localparam bit FIFO_MODE_STD  = 1'b0;
  localparam bit FIFO_MODE_FWFT = 1'b1;

  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Depth must be a power of two so the pointer wrap toggle falls out of plain increment.
  function automatic bit fifo_params_legal(input int width, input int depth,
                                           input int af_level, input int ae_level);
    return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// Storage for the FIFO: register array with one synchronous write port and one
// combinational read port. Contents are never reset.
module fifo_mem_1r1w
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [fifo_clog2(DEPTH)-1:0]  waddr_i,
  input  logic [WIDTH-1:0]              wdata_i,
  input  logic [fifo_clog2(DEPTH)-1:0]  raddr_i,
  output logic [WIDTH-1:0]              rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// standard or first-word-fall-through read mode and synchronous flush.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = FIFO_MODE_STD
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        clear_i,
  input  logic                        wr_en_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        rd_en_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        rvalid_o,
  output logic                        full_o,
  output logic                        almost_full_o,
  output logic                        empty_o,
  output logic                        almost_empty_o,
  output logic [fifo_clog2(DEPTH):0]  count_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);

  localparam int AW = fifo_clog2(DEPTH);
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);

  if (!fifo_params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("sync_fifo: illegal parameters (need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH, DEPTH pow2 >= 2)");
  end

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full_w, empty_w, wr_acc, rd_acc;
  logic [WIDTH-1:0] head_data;

  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A full FIFO still takes a write when the same edge pops a word.
  assign rd_acc = rd_en_i & ~empty_w & ~clear_i;
  assign wr_acc = wr_en_i & (~full_w | rd_acc) & ~clear_i;

  fifo_mem_1r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wdata_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head_data)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(rd_acc);
    rvalid_d    = rd_acc;
    overflow_d  = wr_en_i & ~wr_acc & ~clear_i;
    underflow_d = rd_en_i & ~rd_acc & ~clear_i;
    rdata_d     = rdata_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      rvalid_d = 1'b0;
    end
    // In FWFT mode rdata_q keeps the last presented head so the output holds once empty.
    if (rd_acc || (FWFT && clear_i && !empty_w)) begin
      rdata_d = head_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count_o        = wr_ptr_q - rd_ptr_q;
  assign full_o         = full_w;
  assign empty_o        = empty_w;
  assign almost_full_o  = (count_o >= AF_CNT);
  assign almost_empty_o = (count_o <= AE_CNT);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;
  assign rdata_o        = (FWFT && !empty_w) ? head_data : rdata_q;
  assign rvalid_o       = FWFT ? !empty_w : rvalid_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one standard-read and one FWFT instance share
// the same stimulus; expected values are hand-derived per step.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd_en = 1'b0;

  logic [7:0] s_rdata, f_rdata;
  logic       s_rvalid, f_rvalid;
  logic       s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
  logic       f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
  logic [4:0] s_count, f_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b0)) u_std (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(s_rdata), .rvalid_o(s_rvalid), .full_o(s_full),
    .almost_full_o(s_af), .empty_o(s_empty), .almost_empty_o(s_ae), .count_o(s_count),
    .overflow_o(s_ovf), .underflow_o(s_unf)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(f_rdata), .rvalid_o(f_rvalid), .full_o(f_full),
    .almost_full_o(f_af), .empty_o(f_empty), .almost_empty_o(f_ae), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Status vector {full, almost_full, empty, almost_empty, overflow, underflow} plus count.
  task automatic chk_stat(input string tag, input int cnt, input bit ovf, input bit unf);
    logic [5:0] exp;
    exp = {cnt == 16, cnt >= 12, cnt == 0, cnt <= 2, ovf, unf};
    chk({tag, "/std_cnt"}, 32'(s_count), 32'(cnt));
    chk({tag, "/fwft_cnt"}, 32'(f_count), 32'(cnt));
    chk({tag, "/std_flags"}, 32'({s_full, s_af, s_empty, s_ae, s_ovf, s_unf}), 32'(exp));
    chk({tag, "/fwft_flags"}, 32'({f_full, f_af, f_empty, f_ae, f_ovf, f_unf}), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wdata = base + 8'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  function automatic logic [7:0] exp_wrap(input int k);
    return (k < 16) ? 8'(8'h20 + k) : 8'(8'h30 + k - 16);
  endfunction

  initial begin
    // 1: reset then idle
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) step();
    chk_stat("reset", 0, 1'b0, 1'b0);
    chk("reset/rvalid", 32'({s_rvalid, f_rvalid}), 32'h0);
    chk("reset/std_rdata", 32'(s_rdata), 32'h0);
    chk("reset/fwft_rdata", 32'(f_rdata), 32'h0);

    // 2: fill to full, then one rejected write
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h10 + i);
      step();
      chk_stat($sformatf("fill%0d", i), i + 1, 1'b0, 1'b0);
      chk($sformatf("fill%0d/fwft_head", i), 32'({f_rvalid, f_rdata}), 32'h110);
    end
    wdata = 8'h99;
    step();
    chk_stat("overflow", 16, 1'b1, 1'b0);
    wr_en = 1'b0;
    step();
    chk_stat("overflow_end", 16, 1'b0, 1'b0);

    // 3: drain in order, then one rejected read
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d/fwft", i), 32'({f_rvalid, f_rdata}), 32'({1'b1, 8'(8'h10 + i)}));
      rd_en = 1'b1;
      step();
      chk($sformatf("drain%0d/std", i), 32'({s_rvalid, s_rdata}), 32'({1'b1, 8'(8'h10 + i)}));
      chk_stat($sformatf("drain%0d", i), 15 - i, 1'b0, 1'b0);
    end
    step();
    chk_stat("underflow", 0, 1'b0, 1'b1);
    chk("underflow/rvalid", 32'({s_rvalid, f_rvalid}), 32'h0);
    rd_en = 1'b0;
    step();
    chk_stat("underflow_end", 0, 1'b0, 1'b0);

    // 4: full FIFO with simultaneous write+read across the pointer wrap
    fill(16, 8'h20);
    chk_stat("wrap_full", 16, 1'b0, 1'b0);
    for (int k = 0; k < 36; k++) begin
      wr_en = (k < 20);
      rd_en = 1'b1;
      wdata = 8'(8'h30 + k);
      chk($sformatf("wrap%0d/fwft", k), 32'(f_rdata), 32'(exp_wrap(k)));
      step();
      chk($sformatf("wrap%0d/std", k), 32'({s_rvalid, s_rdata}), 32'({1'b1, exp_wrap(k)}));
      if (k < 20) chk_stat($sformatf("wrap%0d", k), 16, 1'b0, 1'b0);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
    chk_stat("wrap_empty", 0, 1'b0, 1'b0);

    // 5: write+read on an empty FIFO
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'hAA;
    step();
    chk_stat("empty_wr_rd", 1, 1'b0, 1'b1);
    chk("empty_wr_rd/std_rvalid", 32'(s_rvalid), 32'h0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("empty_wr_rd/fwft", 32'({f_rvalid, f_rdata}), 32'h1AA);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty_wr_rd/std", 32'({s_rvalid, s_rdata}), 32'h1AA);
    chk_stat("empty_wr_rd_pop", 0, 1'b0, 1'b0);

    // 6: flush with a concurrent write, flush with a read while empty, async reset
    fill(7, 8'h40);
    chk_stat("pre_clear", 7, 1'b0, 1'b0);
    clear = 1'b1;
    wr_en = 1'b1;
    wdata = 8'h55;
    step();
    chk_stat("clear", 0, 1'b0, 1'b0);
    chk("clear/rvalid", 32'({s_rvalid, f_rvalid}), 32'h0);
    chk("clear/std_hold", 32'(s_rdata), 32'hAA);
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    chk_stat("clear_rd_empty", 0, 1'b0, 1'b0);
    clear = 1'b0;
    rd_en = 1'b0;
    fill(3, 8'h60);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h63;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("burst/std", 32'({s_rvalid, s_rdata}), 32'h160);
    #2 rst_n = 1'b0;
    #1;
    chk_stat("async_rst", 0, 1'b0, 1'b0);
    chk("async_rst/rvalid", 32'({s_rvalid, f_rvalid}), 32'h0);
    chk("async_rst/rdata", 32'({s_rdata, f_rdata}), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk_stat("post_rst", 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
